// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write-side blocks.
package fifo_pkg;

  typedef enum logic {
    WS_IDLE = 1'b0,
    WS_SEND = 1'b1
  } wser_state_t;

endpackage

// File: rtl/fifo_wr_serializer_if.sv
// Word stream in and FIFO write port out of the write-side serializer.
// master = word source plus FIFO side; slave = the serializer.
interface fifo_wr_serializer_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
);
  localparam int IN_W  = DSIZE * RATIO;
  localparam int LEN_W = $clog2(RATIO);

  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_data;
  logic [LEN_W-1:0] s_len;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;

  modport master (
    output s_valid, s_data, s_len, wfull,
    input  s_ready, wdata, winc
  );

  modport slave (
    input  s_valid, s_data, s_len, wfull,
    output s_ready, wdata, winc
  );
endinterface

// File: rtl/fifo_wr_serializer.sv
// Serializes wide words into DSIZE-bit beats on the FIFO write port, stalling
// on wfull without losing or repeating beats.
module fifo_wr_serializer
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_wr_serializer_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int IN_W  = DSIZE * RATIO;
  localparam int LEN_W = $clog2(RATIO);
  localparam int REM_W = LEN_W + 1;
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(RATIO);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  wser_state_t      state_q, state_d;
  logic [IN_W-1:0]  hold_q, hold_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] beat_cnt_q, stall_cnt_q;
  logic             ready;
  logic             sending;
  logic             beat_fire;
  logic             stall;

  // A length field of zero stands for a full word of RATIO beats.
  function automatic logic [REM_W-1:0] len_to_rem(input logic [LEN_W-1:0] len);
    return (len == '0) ? REM_FULL : REM_W'(len);
  endfunction

  function automatic logic [IN_W-1:0] shift_out(input logic [IN_W-1:0] word);
    return (MSB_FIRST != 0) ? (word << DSIZE) : (word >> DSIZE);
  endfunction

  assign sending   = (state_q == WS_SEND);
  assign beat_fire = sending && !bus.wfull;
  assign stall     = sending && bus.wfull;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    ready   = 1'b0;
    unique case (state_q)
      WS_IDLE: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          hold_d  = bus.s_data;
          rem_d   = len_to_rem(bus.s_len);
          state_d = WS_SEND;
        end
      end
      WS_SEND: begin
        ready = (rem_q == REM_ONE) && !bus.wfull;
        if (!bus.wfull) begin
          if (rem_q == REM_ONE) begin
            // Last beat leaves this cycle: reload for zero-bubble or go idle.
            if (bus.s_valid) begin
              hold_d = bus.s_data;
              rem_d  = len_to_rem(bus.s_len);
            end else begin
              state_d = WS_IDLE;
            end
          end else begin
            hold_d = shift_out(hold_q);
            rem_d  = rem_q - REM_ONE;
          end
        end
      end
      default: state_d = WS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= WS_IDLE;
      rem_q   <= '0;
      // NOTE: the hold register is a datapath register but it is reset too,
      // because wdata is read straight from it and must be 0 during reset.
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (beat_fire) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // s_ready is the only combinational input-to-output path (from wfull).
  assign bus.s_ready = ready && wrst_n;
  assign bus.winc    = sending;
  assign bus.wdata   = (MSB_FIRST != 0) ? hold_q[IN_W-1 -: DSIZE] : hold_q[DSIZE-1:0];
  assign busy        = sending;
  assign beat_cnt    = beat_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
